// File: rtl/cpu_control_fsm.sv
// Multi-cycle main controller: fetch, latch, decode, execute/mem/writeback.
// Ports: clk, reset (sync, active-high), instruction fields op_code,
//   ext_op_code, A_index (branch/jump condition), psr_flags; outputs are
//   datapath strobes (instruction_en, pc_en, pc_src, reg_write,
//   reg_write_src, alu_A_src, alu_B_src, alu_cont, loading, storing),
//   mem_we and the debug state encoding.
// Optional: define CPU_CONTROL_HALT_EN to decode op 0000 / ext 0000 as HALT.
module cpu_control_fsm #(
    parameter int ALU_CONT_BITS    = 6,
    parameter int OP_CODE_BITS     = 4,
    parameter int EXT_OP_CODE_BITS = 4,
    parameter int REG_BITS         = 4,
    parameter int WIDTH            = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [OP_CODE_BITS-1:0]     op_code,
    input  logic [EXT_OP_CODE_BITS-1:0] ext_op_code,
    input  logic [REG_BITS-1:0]         A_index,
    input  logic [WIDTH-1:0]            psr_flags,
    output logic                        instruction_en,
    output logic                        pc_en,
    output logic [1:0]                  pc_src,
    output logic                        reg_write,
    output logic [1:0]                  reg_write_src,
    output logic                        alu_A_src,
    output logic                        alu_B_src,
    output logic [ALU_CONT_BITS-1:0]    alu_cont,
    output logic                        loading,
    output logic                        storing,
    output logic                        mem_we,
    output logic [3:0]                  state
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_LATCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_EXEC_R    = 4'd3,
        S_EXEC_I    = 4'd4,
        S_LOAD_ADDR = 4'd5,
        S_LOAD_WB   = 4'd6,
        S_STORE     = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_JAL       = 4'd10,
        S_HALT      = 4'd11
    } state_t;

    localparam logic [1:0] PC_ALU  = 2'd0;
    localparam logic [1:0] PC_REGB = 2'd1;
    localparam logic [1:0] PC_INC  = 2'd2;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC1 = 2'd2;

    state_t state_q, state_d;

    logic is_r, is_i, is_load, is_store, is_jal, is_jmp, is_br, is_halt;
    logic is_cmp, taken;
    logic unused_flags;

    // Only Z and N feed the condition logic.
    assign unused_flags = ^psr_flags;

    assign state = state_q;

    // Instruction class decode
    always_comb begin
        is_r     = 1'b0;
        is_i     = 1'b0;
        is_load  = 1'b0;
        is_store = 1'b0;
        is_jal   = 1'b0;
        is_jmp   = 1'b0;
        is_br    = 1'b0;
        is_halt  = 1'b0;
        case (op_code)
            OP_CODE_BITS'(4'h0): begin
                case (ext_op_code)
                    EXT_OP_CODE_BITS'(4'h5),
                    EXT_OP_CODE_BITS'(4'h9),
                    EXT_OP_CODE_BITS'(4'hB),
                    EXT_OP_CODE_BITS'(4'h1),
                    EXT_OP_CODE_BITS'(4'h2),
                    EXT_OP_CODE_BITS'(4'h3),
                    EXT_OP_CODE_BITS'(4'hD): is_r = 1'b1;
`ifdef CPU_CONTROL_HALT_EN
                    EXT_OP_CODE_BITS'(4'h0): is_halt = 1'b1;
`endif
                    default: ;
                endcase
            end
            OP_CODE_BITS'(4'h5),
            OP_CODE_BITS'(4'h9),
            OP_CODE_BITS'(4'hB),
            OP_CODE_BITS'(4'hD): is_i = 1'b1;
            OP_CODE_BITS'(4'h4): begin
                case (ext_op_code)
                    EXT_OP_CODE_BITS'(4'h0): is_load  = 1'b1;
                    EXT_OP_CODE_BITS'(4'h4): is_store = 1'b1;
                    EXT_OP_CODE_BITS'(4'h8): is_jal   = 1'b1;
                    EXT_OP_CODE_BITS'(4'hC): is_jmp   = 1'b1;
                    default: ;
                endcase
            end
            OP_CODE_BITS'(4'hC): is_br = 1'b1;
            default: ;
        endcase
    end

    // Compares only update flags, so they never write the register file.
    assign is_cmp = (state_q == S_EXEC_R)
                  ? (ext_op_code == EXT_OP_CODE_BITS'(4'hB))
                  : (op_code == OP_CODE_BITS'(4'hB));

    // Branch/jump condition from A_index against Z (bit 6) and N (bit 7)
    always_comb begin
        taken = 1'b0;
        case (A_index)
            REG_BITS'(4'h0): taken = psr_flags[6];
            REG_BITS'(4'h1): taken = ~psr_flags[6];
            REG_BITS'(4'hC): taken = psr_flags[7];
            REG_BITS'(4'hD): taken = ~psr_flags[7];
            REG_BITS'(4'hE): taken = 1'b1;
            default:         taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        instruction_en = 1'b0;
        pc_en          = 1'b0;
        pc_src         = PC_INC;
        reg_write      = 1'b0;
        reg_write_src  = WB_ALU;
        alu_A_src      = 1'b0;
        alu_B_src      = 1'b0;
        alu_cont       = '0;
        loading        = 1'b0;
        storing        = 1'b0;
        mem_we         = 1'b0;
        // Reset suppresses every strobe in the cycle it is sampled.
        if (!reset) begin
            unique case (state_q)
                S_FETCH: state_d = S_LATCH;
                S_LATCH: begin
                    instruction_en = 1'b1;
                    state_d        = S_DECODE;
                end
                S_DECODE: begin
                    unique case (1'b1)
                        is_r:     state_d = S_EXEC_R;
                        is_i:     state_d = S_EXEC_I;
                        is_load:  state_d = S_LOAD_ADDR;
                        is_store: state_d = S_STORE;
                        is_br:    state_d = S_BRANCH;
                        is_jmp:   state_d = S_JUMP;
                        is_jal:   state_d = S_JAL;
                        is_halt:  state_d = S_HALT;
                        default: begin
                            // NOP retires here
                            pc_en   = 1'b1;
                            state_d = S_FETCH;
                        end
                    endcase
                end
                S_EXEC_R, S_EXEC_I: begin
                    alu_A_src = 1'b1;
                    alu_B_src = (state_q == S_EXEC_I);
                    alu_cont  = (state_q == S_EXEC_R)
                              ? ALU_CONT_BITS'({2'b00, ext_op_code})
                              : ALU_CONT_BITS'({2'b01, op_code});
                    reg_write = ~is_cmp;
                    pc_en     = 1'b1;
                    state_d   = S_FETCH;
                end
                S_LOAD_ADDR: begin
                    loading = 1'b1;
                    state_d = S_LOAD_WB;
                end
                S_LOAD_WB: begin
                    loading       = 1'b1;
                    reg_write     = 1'b1;
                    reg_write_src = WB_MEM;
                    pc_en         = 1'b1;
                    state_d       = S_FETCH;
                end
                S_STORE: begin
                    storing = 1'b1;
                    mem_we  = 1'b1;
                    pc_en   = 1'b1;
                    state_d = S_FETCH;
                end
                S_BRANCH: begin
                    alu_A_src = 1'b0;
                    alu_B_src = 1'b1;
                    alu_cont  = ALU_CONT_BITS'(6'b000101);
                    pc_en     = 1'b1;
                    pc_src    = taken ? PC_ALU : PC_INC;
                    state_d   = S_FETCH;
                end
                S_JUMP: begin
                    pc_en   = 1'b1;
                    pc_src  = taken ? PC_REGB : PC_INC;
                    state_d = S_FETCH;
                end
                S_JAL: begin
                    reg_write     = 1'b1;
                    reg_write_src = WB_PC1;
                    pc_en         = 1'b1;
                    pc_src        = PC_REGB;
                    state_d       = S_FETCH;
                end
`ifdef CPU_CONTROL_HALT_EN
                S_HALT: state_d = S_HALT;
`else
                S_HALT: state_d = S_FETCH;
`endif
                default: state_d = S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Testbench for cpu_control_fsm: table of instructions with per-cycle
// expected outputs queued as a scoreboard, plus reset/halt sequences.
module tb_cpu_control_fsm;

    logic        clk;
    logic        reset;
    logic [3:0]  op_code;
    logic [3:0]  ext_op_code;
    logic [3:0]  A_index;
    logic [15:0] psr_flags;
    logic        instruction_en;
    logic        pc_en;
    logic [1:0]  pc_src;
    logic        reg_write;
    logic [1:0]  reg_write_src;
    logic        alu_A_src;
    logic        alu_B_src;
    logic [5:0]  alu_cont;
    logic        loading;
    logic        storing;
    logic        mem_we;
    logic [3:0]  state;

    cpu_control_fsm dut (
        .clk            (clk),
        .reset          (reset),
        .op_code        (op_code),
        .ext_op_code    (ext_op_code),
        .A_index        (A_index),
        .psr_flags      (psr_flags),
        .instruction_en (instruction_en),
        .pc_en          (pc_en),
        .pc_src         (pc_src),
        .reg_write      (reg_write),
        .reg_write_src  (reg_write_src),
        .alu_A_src      (alu_A_src),
        .alu_B_src      (alu_B_src),
        .alu_cont       (alu_cont),
        .loading        (loading),
        .storing        (storing),
        .mem_we         (mem_we),
        .state          (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] st;
        logic       ie;
        logic       pce;
        logic [1:0] pcs;
        logic       rw;
        logic [1:0] rws;
        logic       aa;
        logic       ab;
        logic [5:0] alu;
        logic       ld;
        logic       sd;
        logic       we;
    } exp_t;

    typedef struct {
        string      name;
        logic [3:0] op;
        logic [3:0] ext;
        logic [3:0] aidx;
        logic [15:0] flags;
        int         nterm;
        exp_t       t1;
        exp_t       t2;
    } vec_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    function automatic exp_t mk(input int st, input int pce, input int pcs,
                                input int rw, input int rws, input int aa,
                                input int ab, input int alu, input int ld,
                                input int sd, input int we);
        exp_t e;
        e.st  = 4'(st);
        e.ie  = 1'b0;
        e.pce = 1'(pce);
        e.pcs = 2'(pcs);
        e.rw  = 1'(rw);
        e.rws = 2'(rws);
        e.aa  = 1'(aa);
        e.ab  = 1'(ab);
        e.alu = 6'(alu);
        e.ld  = 1'(ld);
        e.sd  = 1'(sd);
        e.we  = 1'(we);
        return e;
    endfunction

    function automatic exp_t get_act();
        exp_t a;
        a.st  = state;
        a.ie  = instruction_en;
        a.pce = pc_en;
        a.pcs = pc_src;
        a.rw  = reg_write;
        a.rws = reg_write_src;
        a.aa  = alu_A_src;
        a.ab  = alu_B_src;
        a.alu = alu_cont;
        a.ld  = loading;
        a.sd  = storing;
        a.we  = mem_we;
        return a;
    endfunction

    task automatic add(input string nm, input int op, input int ext,
                       input int aidx, input int flags, input int n,
                       input exp_t t1, input exp_t t2);
        vec_t v;
        v.name  = nm;
        v.op    = 4'(op);
        v.ext   = 4'(ext);
        v.aidx  = 4'(aidx);
        v.flags = 16'(flags);
        v.nterm = n;
        v.t1    = t1;
        v.t2    = t2;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Enter at a negedge with the DUT in FETCH; leave the same way.
    task automatic run_vec(input vec_t v);
        exp_t e, a, lat, dec;
        int total;
        op_code     = v.op;
        ext_op_code = v.ext;
        A_index     = v.aidx;
        psr_flags   = v.flags;
        lat    = mk(1, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0);
        lat.ie = 1'b1;
        dec    = mk(2, (v.nterm == 0) ? 1 : 0, 2, 0, 0, 0, 0, 0, 0, 0, 0);
        sb.push_back(mk(0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0));
        sb.push_back(lat);
        sb.push_back(dec);
        if (v.nterm > 0) sb.push_back(v.t1);
        if (v.nterm > 1) sb.push_back(v.t2);
        total = 3 + v.nterm;
        for (int k = 0; k < total; k++) begin
            #1;
            a = get_act();
            e = sb.pop_front();
            tests++;
            if (a !== e) begin
                fails++;
                $display("FAIL %s cyc%0d: got %h expected %h",
                         v.name, k, a, e);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t z;
        z = '0;
        add("ADD",   4'h0, 4'h5, 0, 0, 1, mk(3,1,2,1,0,1,0,'h05,0,0,0), z);
        add("SUB",   4'h0, 4'h9, 0, 0, 1, mk(3,1,2,1,0,1,0,'h09,0,0,0), z);
        add("CMP",   4'h0, 4'hB, 0, 0, 1, mk(3,1,2,0,0,1,0,'h0B,0,0,0), z);
        add("AND",   4'h0, 4'h1, 0, 0, 1, mk(3,1,2,1,0,1,0,'h01,0,0,0), z);
        add("MOV",   4'h0, 4'hD, 0, 0, 1, mk(3,1,2,1,0,1,0,'h0D,0,0,0), z);
        add("ADDI",  4'h5, 4'h7, 0, 0, 1, mk(4,1,2,1,0,1,1,'h15,0,0,0), z);
        add("CMPI",  4'hB, 4'h0, 0, 0, 1, mk(4,1,2,0,0,1,1,'h1B,0,0,0), z);
        add("MOVI",  4'hD, 4'h3, 0, 0, 1, mk(4,1,2,1,0,1,1,'h1D,0,0,0), z);
        add("LOAD",  4'h4, 4'h0, 0, 0, 2, mk(5,0,2,0,0,0,0,0,1,0,0),
                                          mk(6,1,2,1,1,0,0,0,1,0,0));
        add("STOR",  4'h4, 4'h4, 0, 0, 1, mk(7,1,2,0,0,0,0,0,0,1,1), z);
        add("BEQ_T", 4'hC, 4'h0, 4'h0, 16'h0040, 1,
            mk(8,1,0,0,0,0,1,'h05,0,0,0), z);
        add("BEQ_N", 4'hC, 4'h0, 4'h0, 16'hFFBF, 1,
            mk(8,1,2,0,0,0,1,'h05,0,0,0), z);
        add("BNE_T", 4'hC, 4'h0, 4'h1, 16'h0000, 1,
            mk(8,1,0,0,0,0,1,'h05,0,0,0), z);
        add("BLT_T", 4'hC, 4'h0, 4'hC, 16'h0080, 1,
            mk(8,1,0,0,0,0,1,'h05,0,0,0), z);
        add("BGE_N", 4'hC, 4'h0, 4'hD, 16'h0080, 1,
            mk(8,1,2,0,0,0,1,'h05,0,0,0), z);
        add("JUC",   4'h4, 4'hC, 4'hE, 16'h0000, 1,
            mk(9,1,1,0,0,0,0,0,0,0,0), z);
        add("JNEVER",4'h4, 4'hC, 4'h2, 16'hFFFF, 1,
            mk(9,1,2,0,0,0,0,0,0,0,0), z);
        add("JAL",   4'h4, 4'h8, 0, 0, 1, mk(10,1,1,1,2,0,0,0,0,0,0), z);
        add("NOP1",  4'h1, 4'h0, 0, 0, 0, z, z);
        add("NOP4",  4'h4, 4'h1, 0, 0, 0, z, z);
`ifndef CPU_CONTROL_HALT_EN
        add("NOP00", 4'h0, 4'h0, 0, 0, 0, z, z);
`endif

        reset       = 1'b1;
        op_code     = 4'h1;
        ext_op_code = 4'h0;
        A_index     = 4'h0;
        psr_flags   = 16'h0;

        // reset held two cycles
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1;
            chk("rst_state", 32'(state), 0);
            chk("rst_pc_en", 32'(pc_en), 0);
            chk("rst_pc_src", 32'(pc_src), 2);
            chk("rst_ie", 32'(instruction_en), 0);
        end
        reset = 1'b0;
        #1;
        chk("rel_ie0", 32'(instruction_en), 0);
        @(negedge clk); #1;
        chk("rel_ie1", 32'(instruction_en), 1);
        chk("rel_state1", 32'(state), 1);
        @(negedge clk);
        @(negedge clk);

        foreach (vecs[i]) run_vec(vecs[i]);

        // reset during LOAD_ADDR: no LOAD_WB write follows
        op_code     = 4'h4;
        ext_op_code = 4'h0;
        repeat (3) @(negedge clk);
        #1;
        chk("ld_state5", 32'(state), 5);
        chk("ld_loading", 32'(loading), 1);
        reset = 1'b1;
        #1;
        chk("ldrst_rw", 32'(reg_write), 0);
        chk("ldrst_pce", 32'(pc_en), 0);
        @(negedge clk); #1;
        chk("ldrst_state", 32'(state), 0);
        chk("ldrst_rw2", 32'(reg_write), 0);
        reset = 1'b0;
        run_vec(vecs[0]);

        // reset during STORE suppresses the write strobe
        op_code     = 4'h4;
        ext_op_code = 4'h4;
        repeat (3) @(negedge clk);
        #1;
        chk("st_we", 32'(mem_we), 1);
        reset = 1'b1;
        #1;
        chk("strst_we", 32'(mem_we), 0);
        chk("strst_pce", 32'(pc_en), 0);
        @(negedge clk); #1;
        chk("strst_state", 32'(state), 0);
        reset = 1'b0;
        run_vec(vecs[9]);

`ifdef CPU_CONTROL_HALT_EN
        op_code     = 4'h0;
        ext_op_code = 4'h0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("halt_state", 32'(state), 11);
            chk("halt_pce", 32'(pc_en), 0);
            chk("halt_pcs", 32'(pc_src), 2);
            @(negedge clk);
        end
        reset = 1'b1;
        @(negedge clk); #1;
        chk("halt_rst", 32'(state), 0);
        reset = 1'b0;
        run_vec(vecs[0]);
`endif

        chk("sb_empty", 32'(sb.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
